// File: rtl/instruction_sequencer.sv
// instruction_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM
// for the instruction-type mux/ALU datapath, with one instruction in flight.
// Optional feature macro: SEQ_PERF_COUNTERS_EN (cycle/instret counters).
module instruction_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 8
) (
    input  logic        iCLK,
    input  logic        iRST,
    output logic        oIMEM_REQ,
    output logic [31:0] oIMEM_ADDR,
    input  logic        iIMEM_ACK,
    input  logic [31:0] iIMEM_DATA,
    output logic [31:0] oIR,
    output logic [6:0]  oOpcode,
    output logic [2:0]  oALU_SEL,
    input  logic [31:0] iALU_OUT,
    input  logic        iBR_TAKEN,
    output logic        oDMEM_REQ,
    output logic        oDMEM_WE,
    input  logic        iDMEM_ACK,
    output logic        oRF_WE,
    output logic        oRETIRE,
    output logic        oILLEGAL,
    output logic [31:0] oCYCLE_CNT,
    output logic [31:0] oINSTRET_CNT
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_R  = 3'd0;
    localparam logic [SEL_W-1:0] SEL_I1 = 3'd1;
    localparam logic [SEL_W-1:0] SEL_I2 = 3'd2;
    localparam logic [SEL_W-1:0] SEL_S  = 3'd3;
    localparam logic [SEL_W-1:0] SEL_B  = 3'd4;
    localparam logic [SEL_W-1:0] SEL_J1 = 3'd5;
    localparam logic [SEL_W-1:0] SEL_J2 = 3'd6;
    localparam logic [SEL_W-1:0] SEL_U  = 3'd7;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    state_t             state, stateNext;
    logic [XLEN-1:0]    pc, pcNext;
    logic [XLEN-1:0]    npc, npcNext;
    logic [XLEN-1:0]    irNext;
    logic [SEL_W-1:0]   selNext;
    logic [CNT_W-1:0]   waitCnt, waitNext;
    logic [XLEN-1:0]    target;
    logic               timedOut;
    logic               imemReqNext, dmemReqNext, dmemWeNext;
    logic               rfWeNext, retireNext, illegalNext;

    assign oIMEM_ADDR = pc;
    assign oOpcode    = oIR[6:0];
    // The ack cycle that would be the last allowed one still counts as success.
    assign timedOut   = (waitCnt == CNT_W'(MEM_TIMEOUT - 1));

    // Next-state, datapath-register and registered-output next values
    always_comb begin
        stateNext = state;
        pcNext    = pc;
        npcNext   = npc;
        irNext    = oIR;
        selNext   = oALU_SEL;
        waitNext  = waitCnt;
        target    = pc + 32'd4;

        case (state)
            FETCH: begin
                if (iIMEM_ACK) begin
                    irNext    = iIMEM_DATA;
                    stateNext = DECODE;
                end else if (timedOut) begin
                    stateNext = TRAP;
                end else begin
                    waitNext = waitCnt + CNT_W'(1);
                end
            end
            DECODE: begin
                stateNext = EXEC;
                case (oIR[6:0])
                    7'h33:   selNext = SEL_R;
                    7'h13:   selNext = SEL_I1;
                    7'h03:   selNext = SEL_I2;
                    7'h23:   selNext = SEL_S;
                    7'h63:   selNext = SEL_B;
                    7'h6F:   selNext = SEL_J1;
                    7'h67:   selNext = SEL_J2;
                    7'h37:   selNext = SEL_U;
                    default: stateNext = TRAP;
                endcase
            end
            EXEC: begin
                if ((oALU_SEL == SEL_B && iBR_TAKEN) || oALU_SEL == SEL_J1) begin
                    target = iALU_OUT;
                end else if (oALU_SEL == SEL_J2) begin
                    target = iALU_OUT & ~32'h1;
                end
                // Misaligned targets trap without touching the PC.
                if (target[1:0] != 2'b00) begin
                    stateNext = TRAP;
                end else begin
                    npcNext   = target;
                    stateNext = (oALU_SEL == SEL_I2 || oALU_SEL == SEL_S) ? MEM : WB;
                end
            end
            MEM: begin
                if (iDMEM_ACK) begin
                    stateNext = WB;
                end else if (timedOut) begin
                    stateNext = TRAP;
                end else begin
                    waitNext = waitCnt + CNT_W'(1);
                end
            end
            WB: begin
                pcNext    = npc;
                stateNext = FETCH;
            end
            TRAP:    stateNext = TRAP;
            default: stateNext = TRAP;
        endcase

        if (stateNext != state) begin
            waitNext = '0;
        end

        imemReqNext = (stateNext == FETCH);
        dmemReqNext = (stateNext == MEM);
        dmemWeNext  = (stateNext == MEM) && (selNext == SEL_S);
        rfWeNext    = (stateNext == WB) && (selNext != SEL_S) && (selNext != SEL_B);
        retireNext  = (stateNext == WB);
        illegalNext = oILLEGAL || (stateNext == TRAP);
    end

    // State, datapath registers and registered outputs
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            npc       <= RESET_PC;
            oIR       <= '0;
            oALU_SEL  <= '0;
            waitCnt   <= '0;
            oIMEM_REQ <= 1'b1;
            oDMEM_REQ <= 1'b0;
            oDMEM_WE  <= 1'b0;
            oRF_WE    <= 1'b0;
            oRETIRE   <= 1'b0;
            oILLEGAL  <= 1'b0;
        end else begin
            state     <= stateNext;
            pc        <= pcNext;
            npc       <= npcNext;
            oIR       <= irNext;
            oALU_SEL  <= selNext;
            waitCnt   <= waitNext;
            oIMEM_REQ <= imemReqNext;
            oDMEM_REQ <= dmemReqNext;
            oDMEM_WE  <= dmemWeNext;
            oRF_WE    <= rfWeNext;
            oRETIRE   <= retireNext;
            oILLEGAL  <= illegalNext;
        end
    end

`ifdef SEQ_PERF_COUNTERS_EN
    logic [31:0] cycleCnt, instretCnt;

    // Running cycle and retired-instruction counters, frozen while trapped
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            cycleCnt   <= '0;
            instretCnt <= '0;
        end else begin
            if (state != TRAP) begin
                cycleCnt <= cycleCnt + 32'd1;
            end
            if (oRETIRE) begin
                instretCnt <= instretCnt + 32'd1;
            end
        end
    end

    assign oCYCLE_CNT   = cycleCnt;
    assign oINSTRET_CNT = instretCnt;
`else
    assign oCYCLE_CNT   = '0;
    assign oINSTRET_CNT = '0;
`endif

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed scoreboard bench for instruction_sequencer.
module tb_instruction_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        iCLK, iRST;
    logic        oIMEM_REQ, iIMEM_ACK;
    logic [31:0] oIMEM_ADDR, iIMEM_DATA, oIR, iALU_OUT;
    logic [6:0]  oOpcode;
    logic [2:0]  oALU_SEL;
    logic        iBR_TAKEN, oDMEM_REQ, oDMEM_WE, iDMEM_ACK;
    logic        oRF_WE, oRETIRE, oILLEGAL;
    logic [31:0] oCYCLE_CNT, oINSTRET_CNT;

    instruction_sequencer #(.RESET_PC(RST_PC), .MEM_TIMEOUT(8)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .oIMEM_REQ(oIMEM_REQ), .oIMEM_ADDR(oIMEM_ADDR),
        .iIMEM_ACK(iIMEM_ACK), .iIMEM_DATA(iIMEM_DATA),
        .oIR(oIR), .oOpcode(oOpcode), .oALU_SEL(oALU_SEL),
        .iALU_OUT(iALU_OUT), .iBR_TAKEN(iBR_TAKEN),
        .oDMEM_REQ(oDMEM_REQ), .oDMEM_WE(oDMEM_WE), .iDMEM_ACK(iDMEM_ACK),
        .oRF_WE(oRF_WE), .oRETIRE(oRETIRE), .oILLEGAL(oILLEGAL),
        .oCYCLE_CNT(oCYCLE_CNT), .oINSTRET_CNT(oINSTRET_CNT)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic        wr;
        logic [31:0] npc;
        logic [2:0]  sel;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] modelPc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    function automatic logic [2:0] selOf(input logic [6:0] op);
        case (op)
            7'h33:   return 3'd0;
            7'h13:   return 3'd1;
            7'h03:   return 3'd2;
            7'h23:   return 3'd3;
            7'h63:   return 3'd4;
            7'h6F:   return 3'd5;
            7'h67:   return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

    task automatic doReset();
        iRST = 1'b1;
        tick();
        check("rst_imem_addr", oIMEM_ADDR, RST_PC);
        check("rst_imem_req", 32'(oIMEM_REQ), 32'd1);
        check("rst_ir", oIR, 32'd0);
        check("rst_alu_sel", 32'(oALU_SEL), 32'd0);
        check("rst_dmem_req", 32'(oDMEM_REQ), 32'd0);
        check("rst_rf_we", 32'(oRF_WE), 32'd0);
        check("rst_retire", 32'(oRETIRE), 32'd0);
        check("rst_illegal", 32'(oILLEGAL), 32'd0);
        check("rst_cycle_cnt", oCYCLE_CNT, 32'd0);
        check("rst_instret_cnt", oINSTRET_CNT, 32'd0);
        iRST = 1'b0;
        modelPc = RST_PC;
        sb.delete();
    endtask

    // Drive one legal, non-trapping instruction from FETCH through WB.
    task automatic runInstr(input logic [31:0] word, input int imemWait, input int dmemWait,
                            input logic [31:0] aluOut, input logic brTaken);
        exp_t        e;
        logic [2:0]  sel;
        logic [31:0] npc;
        logic        isMem;
        int          cycles;
        sel = selOf(word[6:0]);
        if ((word[6:0] == 7'h63 && brTaken) || word[6:0] == 7'h6F) npc = aluOut;
        else if (word[6:0] == 7'h67) npc = aluOut & ~32'h1;
        else npc = modelPc + 32'd4;
        isMem = (sel == 3'd2) || (sel == 3'd3);
        e.wr = !((sel == 3'd3) || (sel == 3'd4));
        e.npc = npc;
        e.sel = sel;
        sb.push_back(e);
        cycles = 0;

        check("fetch_addr", oIMEM_ADDR, modelPc);
        for (int i = 0; i < imemWait; i++) begin
            check("imem_req_wait", 32'(oIMEM_REQ), 32'd1);
            tick();
            cycles++;
        end
        check("imem_req", 32'(oIMEM_REQ), 32'd1);
        iIMEM_ACK = 1'b1;
        iIMEM_DATA = word;
        tick();
        cycles++;
        iIMEM_ACK = 1'b0;
        iIMEM_DATA = 32'hDEAD_BEEF;
        check("ir_latched", oIR, word);
        check("imem_req_drop", 32'(oIMEM_REQ), 32'd0);
        tick();
        cycles++;
        check("alu_sel", 32'(oALU_SEL), 32'(sb[0].sel));
        iALU_OUT = aluOut;
        iBR_TAKEN = brTaken;
        tick();
        cycles++;
        iALU_OUT = 32'h0BAD_0001;
        iBR_TAKEN = 1'b0;
        if (isMem) begin
            for (int i = 0; i < dmemWait; i++) begin
                check("dmem_req_wait", 32'(oDMEM_REQ), 32'd1);
                check("dmem_we_wait", 32'(oDMEM_WE), 32'(sel == 3'd3));
                check("rf_we_early", 32'(oRF_WE), 32'd0);
                tick();
                cycles++;
            end
            check("dmem_req", 32'(oDMEM_REQ), 32'd1);
            iDMEM_ACK = 1'b1;
            tick();
            cycles++;
            iDMEM_ACK = 1'b0;
        end
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("dmem_req_wb", 32'(oDMEM_REQ), 32'd0);
            check("rf_we", 32'(oRF_WE), 32'(e.wr));
            check("retire", 32'(oRETIRE), 32'd1);
            tick();
            cycles++;
            check("next_fetch", oIMEM_ADDR, e.npc);
            check("retire_pulse", 32'(oRETIRE), 32'd0);
            check("latency", 32'(cycles), 32'(imemWait + 4 + (isMem ? dmemWait + 1 : 0)));
            modelPc = e.npc;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        iRST = 1'b1;
        iIMEM_ACK = 1'b0;
        iIMEM_DATA = 32'h0;
        iALU_OUT = 32'h0;
        iBR_TAKEN = 1'b0;
        iDMEM_ACK = 1'b0;
        tick();
        doReset();

        runInstr(32'h0020_81B3, 0, 0, 32'h0, 1'b0);             // add -> 0x104
        runInstr(32'h0000_A103, 0, 3, 32'h0, 1'b0);             // load, 8 cycles
        runInstr(32'h0020_A023, 2, 0, 32'h0, 1'b0);             // store, slow fetch
        runInstr(32'h0010_8093, 7, 0, 32'h0, 1'b0);             // fetch ack on last allowed cycle
        runInstr(32'h0000_A103, 0, 7, 32'h0, 1'b0);             // load ack on last allowed cycle
        runInstr(32'h0000_12B7, 0, 0, 32'h0, 1'b0);             // lui
        runInstr(32'h0080_006F, 0, 0, 32'h0000_0200, 1'b0);     // jal -> 0x200
        runInstr(32'h0020_8463, 0, 0, 32'h0000_0208, 1'b1);     // branch taken -> 0x208
        runInstr(32'h0000_8067, 0, 0, 32'h0000_0201, 1'b0);     // jalr masks bit0 -> 0x200
        runInstr(32'h0020_8463, 0, 0, 32'h0000_0300, 1'b0);     // branch not taken -> 0x204
        runInstr(32'h0080_006F, 0, 0, 32'hFFFF_FFFC, 1'b0);     // jump to top of memory
        runInstr(32'h0020_81B3, 0, 0, 32'h0, 1'b0);             // PC+4 wraps to 0

        // Reset in the middle of a store's MEM phase, then a late ack.
        iIMEM_ACK = 1'b1;
        iIMEM_DATA = 32'h0020_A023;
        tick();
        iIMEM_ACK = 1'b0;
        tick();
        tick();
        check("mid_store_dmem_req", 32'(oDMEM_REQ), 32'd1);
        check("mid_store_dmem_we", 32'(oDMEM_WE), 32'd1);
        tick();
        iRST = 1'b1;
        tick();
        iRST = 1'b0;
        check("abort_addr", oIMEM_ADDR, RST_PC);
        check("abort_dmem_req", 32'(oDMEM_REQ), 32'd0);
        check("abort_retire", 32'(oRETIRE), 32'd0);
        iDMEM_ACK = 1'b1;
        tick();
        iDMEM_ACK = 1'b0;
        check("late_ack_retire", 32'(oRETIRE), 32'd0);
        check("late_ack_rf_we", 32'(oRF_WE), 32'd0);
        check("late_ack_imem_req", 32'(oIMEM_REQ), 32'd1);
        modelPc = RST_PC;
        sb.delete();
        runInstr(32'h0020_81B3, 0, 0, 32'h0, 1'b0);

        // Illegal opcode traps right after DECODE and stays trapped.
        doReset();
        iIMEM_ACK = 1'b1;
        iIMEM_DATA = 32'h0000_000F;
        tick();
        iIMEM_ACK = 1'b0;
        check("illegal_decode_flag", 32'(oILLEGAL), 32'd0);
        tick();
        check("illegal_flag", 32'(oILLEGAL), 32'd1);
        check("illegal_imem_req", 32'(oIMEM_REQ), 32'd0);
        iIMEM_ACK = 1'b1;
        iDMEM_ACK = 1'b1;
        tick();
        tick();
        tick();
        iIMEM_ACK = 1'b0;
        iDMEM_ACK = 1'b0;
        check("trap_sticky", 32'(oILLEGAL), 32'd1);
        check("trap_imem_req", 32'(oIMEM_REQ), 32'd0);
        check("trap_pc_frozen", oIMEM_ADDR, RST_PC);
        check("trap_ir_frozen", oIR, 32'h0000_000F);
        check("trap_retire", 32'(oRETIRE), 32'd0);

        // Misaligned jump target traps, PC untouched.
        doReset();
        iIMEM_ACK = 1'b1;
        iIMEM_DATA = 32'h0080_006F;
        tick();
        iIMEM_ACK = 1'b0;
        tick();
        iALU_OUT = 32'h0000_0302;
        tick();
        check("misalign_flag", 32'(oILLEGAL), 32'd1);
        check("misalign_pc", oIMEM_ADDR, RST_PC);
        check("misalign_rf_we", 32'(oRF_WE), 32'd0);
        tick();
        check("misalign_no_retire", 32'(oRETIRE), 32'd0);

        // Fetch ack withheld for the full timeout window.
        doReset();
        repeat (7) tick();
        check("timeout_not_yet", 32'(oILLEGAL), 32'd0);
        check("timeout_req_held", 32'(oIMEM_REQ), 32'd1);
        tick();
        check("timeout_flag", 32'(oILLEGAL), 32'd1);
        check("timeout_req_drop", 32'(oIMEM_REQ), 32'd0);

        // Ten back-to-back adds for the performance counters.
        doReset();
        for (int n = 0; n < 10; n++) begin
            runInstr(32'h0020_81B3, 0, 0, 32'h0, 1'b0);
        end
`ifdef SEQ_PERF_COUNTERS_EN
        check("instret_cnt", oINSTRET_CNT, 32'd10);
        check("cycle_cnt", oCYCLE_CNT, 32'd40);
`else
        check("instret_cnt_off", oINSTRET_CNT, 32'd0);
        check("cycle_cnt_off", oCYCLE_CNT, 32'd0);
`endif
        check("ten_adds_pc", oIMEM_ADDR, RST_PC + 32'd40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
Name: instruction_sequencer

Overview:
Multi-cycle control FSM that drives the core's instruction-type mux/ALU datapath.
- Fetches an instruction word and holds it stable on oIR/oOpcode.
- Selects the instruction-type path, sequences the data-memory access, and issues register-file writeback and PC update.
- Sits between the instruction/data memory interfaces and instruction_mux; one instruction is in flight at a time.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
MEM_TIMEOUT, 8, max cycles waiting for a memory ack before trapping (range 1..255)

Ports:
iCLK  in  1  clock; all logic on rising edge
iRST  in  1  synchronous, active-high reset
oIMEM_REQ  out  1  instruction fetch request
oIMEM_ADDR  out  32  fetch address = current PC
iIMEM_ACK  in  1  fetch data valid this cycle
iIMEM_DATA  in  32  fetched instruction word
oIR  out  32  latched instruction to datapath
oOpcode  out  7  oIR[6:0]
oALU_SEL  out  3  type select: R=0, I1=1, I2=2, S=3, B=4, J1=5, J2=6, U=7
iALU_OUT  in  32  datapath result / branch-jump target
iBR_TAKEN  in  1  branch condition from datapath, valid in EXEC
oDMEM_REQ  out  1  data memory request
oDMEM_WE  out  1  1 = store, 0 = load; valid with oDMEM_REQ
iDMEM_ACK  in  1  data access complete
oRF_WE  out  1  register-file write strobe, one cycle
oRETIRE  out  1  one-cycle pulse per completed instruction
oILLEGAL  out  1  sticky trap flag
oCYCLE_CNT  out  32  see Optional Feature
oINSTRET_CNT  out  32  see Optional Feature

Behaviour:
- Reset: iRST high at an edge forces, on the next cycle:
  - state=FETCH, PC=RESET_PC
  - oIR=0, oALU_SEL=0, all strobes/requests 0, oILLEGAL=0, timeout counter 0
- Reset mid-operation aborts any outstanding request; no ack arriving after reset is consumed.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP (one-hot or binary, implementer's choice).
- FETCH:
  - oIMEM_REQ=1, oIMEM_ADDR=PC.
  - On iIMEM_ACK: latch iIMEM_DATA into oIR, go to DECODE.
  - If no ack within MEM_TIMEOUT cycles: go to TRAP.
- DECODE, opcode → oALU_SEL:
  - 0x33→R, 0x13→I1, 0x03→I2, 0x23→S, 0x63→B, 0x6F→J1, 0x67→J2, 0x37→U.
  - Any other opcode → TRAP.
  - oALU_SEL is registered and held until the next DECODE.
- EXEC: one cycle for the datapath to settle.
  - I2 or S → MEM; all others → WB.
  - Next PC computed here:
    - B with iBR_TAKEN=1 → iALU_OUT.
    - J1 → iALU_OUT.
    - J2 → iALU_OUT & ~32'h1.
    - Else → PC+4 (wraps modulo 2^32).
  - Next PC with bits[1:0]≠0 → TRAP; PC is not updated.
- MEM:
  - oDMEM_REQ=1; oDMEM_WE=1 for S, 0 for I2.
  - On iDMEM_ACK → WB.
  - MEM_TIMEOUT cycles with no ack → TRAP.
- WB:
  - oRF_WE=1 for R, I1, I2, J1, J2, U; 0 for S and B.
  - oRETIRE=1, PC←next PC, then → FETCH.
- Timeout counter clears on every state entry.
- An ack arriving in the same cycle the counter reaches MEM_TIMEOUT counts as success.
- TRAP:
  - oILLEGAL=1; all requests and strobes 0; PC and oIR frozen.
  - Exit only by iRST.
- Latency with zero-wait acks (ack in first request cycle):
  - Non-memory instruction: 4 cycles, FETCH→WB inclusive.
  - Load/store: 5 cycles.
- Acks outside FETCH/MEM are ignored.
- Requests stay asserted until their ack cycle and drop the cycle after.

Optional Feature:
SEQ_PERF_COUNTERS_EN:
- Defined:
  - oCYCLE_CNT increments every cycle not in reset and not in TRAP.
  - oINSTRET_CNT increments on each oRETIRE.
  - Both are 32-bit, wrap at 2^32, and are cleared by iRST.
- Undefined: both ports are driven constant 0 and no counter logic is generated.

Test Plan:
- Reset, RESET_PC=0x100, zero-wait memory, oIR=0x002081B3 (add) → oIMEM_ADDR=0x100; oALU_SEL=0 in EXEC; oRF_WE and oRETIRE high in cycle 4; next fetch at 0x104.
- Load 0x0000A103 with iDMEM_ACK delayed 3 cycles → oDMEM_REQ=1 and oDMEM_WE=0 for 3 cycles; oRF_WE 1 cycle after ack; total 8 cycles.
- Branch 0x00208463 at PC=0x200:
  - iBR_TAKEN=1, iALU_OUT=0x208 → next fetch 0x208, oRF_WE=0.
  - iBR_TAKEN=0 → next fetch 0x204.
- Faults:
  - Opcode 0x0F → oILLEGAL=1 from cycle after DECODE; oIMEM_REQ stays 0 until reset.
  - J1 with iALU_OUT=0x302 → TRAP.
  - iIMEM_ACK withheld 8 cycles (MEM_TIMEOUT=8) → TRAP.
- iRST pulsed during MEM of a store → next cycle FETCH at RESET_PC, oDMEM_REQ=0, no oRETIRE; a late iDMEM_ACK is ignored.
- With SEQ_PERF_COUNTERS_EN, 10 add instructions, zero-wait memory → oINSTRET_CNT=10, oCYCLE_CNT=40.
